// File: rtl/pps_timer.sv
// pps_timer: local 1 Hz timebase with external PPS measurement, lock, align and a 4-register bus interface
module pps_timer #(
    parameter int CLK_HZ         = 60000000,
    parameter int PULSE_CYCLES   = 6000000,
    parameter int TOL_CYCLES     = 600,
    parameter int TIMEOUT_CYCLES = 90000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pps_in,
    output logic        pps_out,
    output logic        irq,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready
);
    localparam logic [31:0] HZ    = CLK_HZ;
    localparam logic [31:0] LAST  = CLK_HZ - 1;
    localparam logic [31:0] PULSE = PULSE_CYCLES;
    localparam logic [31:0] TOL   = TOL_CYCLES;
    localparam logic [31:0] TO    = TIMEOUT_CYCLES;

    logic        s1, s2, s3;
    logic        ext_seen, locked, new_p, align_arm, irq_en;
    logic [31:0] phase, seconds, period, cap_phase, ext_cnt;

    logic        ext_edge, wrap, acc, wr, ctrl_wr, cap, in_tol;
    logic [31:0] phase_nxt, diff, rd_mux;

    // Edge detect, wrap decision, tolerance test and bus decode
    always_comb begin
        ext_edge  = s2 & ~s3;
        wrap      = (phase == LAST) | (ext_edge & align_arm);
        phase_nxt = wrap ? 32'd0 : phase + 32'd1;
        acc       = sel & ~ready;
        wr        = acc & we;
        ctrl_wr   = wr & (addr == 2'd0);
        cap       = ext_edge & ext_seen;
        diff      = (ext_cnt >= HZ) ? ext_cnt - HZ : HZ - ext_cnt;
        in_tol    = diff <= TOL;
        rd_mux    = (addr == 2'd0) ? {28'd0, irq_en, align_arm, new_p, locked} :
                    (addr == 2'd1) ? period :
                    (addr == 2'd2) ? seconds : cap_phase;
    end

    // Two-flop synchronizer plus a delay flop for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pps_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Local phase, seconds count and registered pulse; a bus write of seconds wins over the tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= LAST;
            seconds <= 32'd0;
            pps_out <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            seconds <= (wr && addr == 2'd2) ? wdata : seconds + 32'(wrap);
            pps_out <= phase_nxt < PULSE;
        end
    end

    // External period measurement with saturating counter; an edge beats a same-cycle timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_cnt   <= 32'd0;
            ext_seen  <= 1'b0;
            locked    <= 1'b0;
            period    <= 32'd0;
            cap_phase <= 32'd0;
        end else begin
            ext_cnt <= ext_edge ? 32'd1 : (ext_cnt == TO) ? ext_cnt : ext_cnt + 32'd1;
            if (ext_edge) begin
                cap_phase <= phase;
                ext_seen  <= 1'b1;
                if (ext_seen) begin
                    period <= ext_cnt;
                    locked <= in_tol;
                end
            end else if (ext_cnt == TO) begin
                locked   <= 1'b0;
                ext_seen <= 1'b0;
            end
        end
    end

    // Control flags: capture beats W1C of new_p, edge beats W1S of align_arm
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            new_p     <= 1'b0;
            align_arm <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            new_p     <= cap | (new_p & ~(ctrl_wr & wdata[1]));
            align_arm <= ~ext_edge & (align_arm | (ctrl_wr & wdata[2]));
            irq_en    <= ctrl_wr ? wdata[3] : irq_en;
            irq       <= irq_en & new_p;
        end
    end

    // One-cycle acknowledge with read data captured on the accepting edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
            rdata <= 32'd0;
        end else begin
            ready <= acc;
            if (acc) rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_pps_timer.sv
// tb_pps_timer: directed bench with an event-time model of the PPS timer checked every cycle
module tb_pps_timer;
    localparam int HZ    = 100;
    localparam int PULSE = 10;
    localparam int TOL   = 2;
    localparam int TO    = 150;

    logic        clk, reset_n, pps_in, sel, we;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic        pps_out, irq, ready;

    pps_timer #(.CLK_HZ(HZ), .PULSE_CYCLES(PULSE), .TOL_CYCLES(TOL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .pps_in(pps_in), .pps_out(pps_out), .irq(irq),
        .sel(sel), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready)
    );

    int total = 0;
    int bad = 0;
    int rises[$];

    int          t, wrap_ref, last_ext, ph, d;
    bit          have_ext, e, acc, wr, seen, irq_n, p1, p2, p3;
    bit          m_locked, m_newp, m_arm, m_irqen, m_irq, m_ready, m_pps;
    logic [31:0] secs, m_period, m_cap, m_rdata, rv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", n, a, x, t);
        end
    endtask

    // Model: phase is the distance from the last wrap, period is the distance between seen edges
    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            t = 0; wrap_ref = -(HZ - 1); secs = 0; have_ext = 0; last_ext = 0;
            m_period = 0; m_cap = 0; m_locked = 0; m_newp = 0; m_arm = 0; m_irqen = 0;
            m_irq = 0; m_ready = 0; m_rdata = 0; m_pps = 0; p1 = 0; p2 = 0; p3 = 0;
        end else begin
            t++;
            e = p2 & ~p3;
            p3 = p2; p2 = p1; p1 = pps_in;
            ph = t - 1 - wrap_ref;
            acc = sel & ~m_ready;
            wr = acc & we;
            rv = (addr == 0) ? {28'd0, m_irqen, m_arm, m_newp, m_locked} :
                 (addr == 1) ? m_period : (addr == 2) ? secs : m_cap;
            irq_n = m_irqen & m_newp;
            seen = have_ext && (t - last_ext <= TO);
            if (ph == HZ - 1 || (e && m_arm)) begin
                wrap_ref = t;
                secs = secs + 1;
            end
            if (wr && addr == 2) secs = wdata;
            m_pps = (t - wrap_ref) < PULSE;
            if (wr && addr == 0 && wdata[1]) m_newp = 0;
            if (wr && addr == 0 && wdata[2]) m_arm = 1;
            if (wr && addr == 0) m_irqen = wdata[3];
            if (e) begin
                m_arm = 0;
                m_cap = ph;
                if (seen) begin
                    d = t - last_ext;
                    m_period = d;
                    m_newp = 1;
                    m_locked = (d >= HZ - TOL) && (d <= HZ + TOL);
                end
                last_ext = t;
                have_ext = 1;
            end else if (have_ext && t - last_ext == TO) m_locked = 0;
            m_ready = acc;
            if (acc) m_rdata = rv;
            m_irq = irq_n;
        end
    end

    // Compare DUT outputs against the model every cycle
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            chk("pps_out", pps_out, m_pps);
            chk("irq", irq, m_irq);
            chk("ready", ready, m_ready);
            if (m_ready) chk("rdata", rdata, m_rdata);
        end
    end

    // External pin: 5-cycle-wide pulse whose first sampled edge is each scheduled index
    initial forever begin
        bit v;
        @(negedge clk);
        v = 0;
        foreach (rises[i]) if (t + 1 >= rises[i] && t + 1 < rises[i] + 5) v = 1;
        pps_in = v;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic at(input int n);
        while (t < n) @(negedge clk);
    endtask

    task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] dv, input bit hold, output logic [31:0] q);
        sel = 1; we = w; addr = a; wdata = dv;
        @(negedge clk);
        q = rdata;
        chk("ack", ready, 1);
        if (hold) @(negedge clk);
        sel = 0; we = 0;
        @(negedge clk);
    endtask

    task automatic rd(input int n, input logic [1:0] a, input logic [31:0] x, input string nm, input bit hold = 0);
        logic [31:0] q;
        at(n - 1);
        bus(0, a, 0, hold, q);
        chk(nm, q, x);
    endtask

    task automatic wrr(input int n, input logic [1:0] a, input logic [31:0] dv);
        logic [31:0] q;
        at(n - 1);
        bus(1, a, dv, 0, q);
    endtask

    initial begin
        reset_n = 0; pps_in = 0; sel = 0; we = 0; addr = 0; wdata = 0; t = 0;
        repeat (3) @(negedge clk);
        chk("rst_pps", pps_out, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        #2 reset_n = 1;
        // free run
        at(1);   chk("pps_c1", pps_out, 1);
        at(10);  chk("pps_c10", pps_out, 1);
        at(11);  chk("pps_c11", pps_out, 0);
        at(101); chk("pps_c101", pps_out, 1);
        at(111); chk("pps_c111", pps_out, 0);
        rd(250, 2, 3, "sec_250");
        // lock
        at(300);
        rises.push_back(310); rises.push_back(410); rises.push_back(510);
        rd(420, 0, 32'h3, "status_lock", 1);
        rd(423, 1, 100, "period_lock");
        wrr(426, 0, 32'h2);
        wrr(429, 0, 32'h8);
        at(431); chk("irq_idle", irq, 0);
        at(512); chk("irq_cap", irq, 0);
        at(513); chk("irq_after", irq, 1);
        wrr(520, 0, 32'hA);
        at(521); chk("irq_w1c", irq, 0);
        // out of tolerance, recovery, W1C racing a capture
        rises.push_back(613); rises.push_back(714); rises.push_back(814);
        rd(620, 1, 103, "period_103");
        rd(623, 0, 32'hA, "status_unlock");
        rd(720, 0, 32'hB, "status_relock");
        wrr(723, 0, 32'hA);
        wrr(816, 0, 32'hA);
        rd(820, 0, 32'hB, "newp_beats_w1c");
        wrr(823, 0, 32'hA);
        // timeout
        rd(966, 0, 32'h9, "pre_timeout");
        rd(968, 0, 32'h8, "post_timeout");
        rises.push_back(1000); rises.push_back(1098);
        rd(1010, 1, 100, "period_kept");
        rd(1013, 0, 32'h8, "status_first_edge");
        rd(1110, 1, 98, "period_98");
        rd(1113, 0, 32'hB, "status_tol_edge");
        wrr(1116, 0, 32'hA);
        // align mid-second
        wrr(1120, 0, 32'hC);
        rises.push_back(1140);
        rd(1130, 2, 12, "sec_pre_align");
        at(1141); chk("pps_pre_align", pps_out, 0);
        at(1142); chk("pps_align", pps_out, 1);
        rd(1145, 2, 13, "sec_align");
        rd(1147, 3, 40, "cap_phase");
        rd(1150, 0, 32'hA, "status_align");
        // align coinciding with natural wrap
        wrr(1200, 0, 32'hC);
        rises.push_back(1240);
        rd(1230, 2, 13, "sec_pre_align2");
        at(1241); chk("pps_pre_align2", pps_out, 0);
        at(1242); chk("pps_align2", pps_out, 1);
        rd(1245, 2, 14, "sec_align2");
        rd(1247, 0, 32'hB, "status_align2");
        // seconds write on a wrap edge
        wrr(1342, 2, 32'h12345678);
        rd(1345, 2, 32'h12345678, "sec_write");
        // asynchronous reset mid-operation with a pending access
        at(1347);
        chk("pps_pre_rst", pps_out, 1);
        chk("irq_pre_rst", irq, 1);
        sel = 1;
        #2 reset_n = 0;
        #1;
        chk("arst_pps", pps_out, 0);
        chk("arst_irq", irq, 0);
        chk("arst_ready", ready, 0);
        chk("arst_rdata", rdata, 0);
        sel = 0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1;
        at(1); chk("pps_rerun", pps_out, 1);
        rd(5, 2, 1, "sec_rerun");
        at(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pps_timer.md
Name: pps_timer

Overview:
- Pulse-per-second timebase clocked by the 60 MHz PPS PLL output (27 MHz in, ×20/9).
- Generates a local 1 Hz pulse and counts seconds.
- Measures an external PPS input (e.g. GPS) in clock cycles, reports lock, and can realign local phase to the external edge.
- Exposes a 4-register memory-mapped interface to the picorv32 bus.

Parameters:
- CLK_HZ, 60000000: cycles per local second. Phase counter wraps at CLK_HZ-1.
- PULSE_CYCLES, 6000000: pps_out high time in cycles. Must satisfy 1 ≤ PULSE_CYCLES < CLK_HZ.
- TOL_CYCLES, 600: allowed |measured period − CLK_HZ| for lock.
- TIMEOUT_CYCLES, 90000000: cycles without an external edge before lock is lost. Must be > CLK_HZ.

Ports:
- clk, input, 1: PLL clock, 60 MHz.
- reset_n, input, 1: asynchronous active-low reset.
- pps_in, input, 1: external PPS. Asynchronous to clk.
- pps_out, output, 1: local PPS pulse, registered.
- irq, output, 1: interrupt request, level.
- sel, input, 1: bus select. Held until ready.
- we, input, 1: write enable, qualified by sel.
- addr, input, 2: register index.
- wdata, input, 32: write data.
- rdata, output, 32: read data, valid while ready=1.
- ready, output, 1: one-cycle bus acknowledge.

Behaviour:
- Reset values:
  - pps_out=0, irq=0, ready=0, rdata=0.
  - phase=CLK_HZ-1, seconds=0.
  - period=0, cap_phase=0, ext_cnt=0.
  - ext_seen=0, locked=0, new_p=0, align_arm=0, irq_en=0.
  - Synchronizer flops = 0.
- Input sync and edge detect:
  - pps_in passes through a 2-flop synchronizer plus one delay flop.
  - ext_edge = s2 & ~s3, high for one cycle.
  - A pin rise sampled at clock edge k makes ext_edge act at edge k+2.
- Local phase counter:
  - Each cycle: if wrap_cond, phase←0 and seconds←seconds+1 (32-bit, wraps modulo 2^32); otherwise phase←phase+1.
  - wrap_cond = (phase==CLK_HZ-1) | (ext_edge & align_arm).
  - Align and natural wrap in the same cycle cause a single increment.
  - pps_out ← (next phase < PULSE_CYCLES).
  - First wrap occurs on the first edge after reset release: pps_out=1 and seconds=1 from that cycle.
- Align:
  - Writing 1 to CTRL bit2 sets align_arm.
  - On the next ext_edge: phase restarts at 0, pps_out rises at that same edge, align_arm clears.
  - Align is honoured whether or not locked.
- External measurement:
  - ext_cnt increments each cycle, saturating at TIMEOUT_CYCLES.
  - On ext_edge:
    - cap_phase←phase (pre-update value).
    - If ext_seen: period←ext_cnt, new_p←1, locked←(|ext_cnt−CLK_HZ| ≤ TOL_CYCLES).
    - Then ext_cnt←1 and ext_seen←1.
  - The first edge after reset or timeout updates no period.
- Timeout:
  - When ext_cnt==TIMEOUT_CYCLES and no ext_edge: locked←0, ext_seen←0.
  - An ext_edge in that same cycle takes priority.
- irq = irq_en & new_p, registered.
- Bus:
  - In a cycle with sel & ~ready: ready←1, rdata←selected register, and any write is applied on that edge.
  - Next cycle ready←0; rdata holds.
  - Addresses and registers:
    - addr 0, CTRL/STATUS, R: bit0 locked, bit1 new_p, bit2 align_arm, bit3 irq_en; other bits 0.
    - addr 0, CTRL/STATUS, W: bit1 W1C new_p; bit2 W1S align_arm; bit3 sets irq_en.
    - addr 1, PERIOD, RO.
    - addr 2, SECONDS, RW: a write loads seconds and overrides a same-cycle increment.
    - addr 3, CAP_PHASE, RO.
  - Writes to RO registers are ignored.
  - new_p set by a capture beats a same-cycle W1C.
  - align_arm clear by ext_edge beats a same-cycle W1S.
- Reset mid-operation: all state returns to reset values immediately (async); the bus transaction is dropped.

Test Plan:
All scenarios use CLK_HZ=100, PULSE_CYCLES=10, TOL_CYCLES=2, TIMEOUT_CYCLES=150, pps_in tied 0 unless stated.
- Free run:
  - Stimulus: release reset, run 300 cycles.
  - Required: pps_out high cycles 1–10, 101–110, 201–210; SECONDS reads 3 at cycle 250.
- Lock:
  - Stimulus: pps_in rises every 100 cycles.
  - Required: after the 2nd edge, PERIOD=100, STATUS=0x3; with irq_en=1, irq=1 the cycle after capture; W1C bit1 → irq=0.
- Out of tolerance:
  - Stimulus: locked, then next edge spacing 103.
  - Required: PERIOD=103, locked=0; spacing 101 restores locked=1.
- Timeout:
  - Stimulus: locked, stop pps_in.
  - Required: locked=0 exactly 150 cycles after the last ext_edge; next single edge leaves PERIOD unchanged; 2nd edge updates it.
- Align:
  - Stimulus: arm via CTRL write; ext_edge arrives while phase=40.
  - Required: CAP_PHASE=40, pps_out rises on that edge, align_arm=0, SECONDS incremented once; ext_edge coinciding with phase=99 also increments once.
- Bus priority:
  - Stimulus: W1C of new_p in the same cycle as a capture.
  - Required: new_p stays 1.
  - Stimulus: write SECONDS=0x12345678 on a wrap cycle.
  - Required: SECONDS reads 0x12345678.
  - Required for every access: ready pulses exactly one cycle per access.
